vcxo_lock_monitor: RTL and testbench
====================================

# vcxo_lock_monitor

Downstream status stage for the VCXO discipline loop. Consumes each freq_error/PWM update from the VCXO controller in the TCXO clock domain and qualifies loop lock with hysteresis. Also produces a block-averaged frequency error and a PWM-rail warning for the control/status register interface.

## Interface
Parameters:
- LOCK_TOL, 10: maximum |freq_error| (×10 Hz units) for a "good" sample while acquiring.
- UNLOCK_TOL, 40: |freq_error| above this is a "bad" sample while locked.
- LOCK_COUNT, 8: consecutive good samples required to declare lock.
- UNLOCK_COUNT, 3: consecutive bad samples required to drop lock.
- AVG_LOG2, 4: averaging block is 2^AVG_LOG2 samples (legal range 0..8).
- PWM_MAX, 40000: PWM full-scale value.
- RAIL_MARGIN, 1000: PWM within this distance of 0 or PWM_MAX counts as railed.

Ports:
- tcxo_clk_in  in  1  TCXO-domain clock, same as the controller's measurement logic.
- reset_n  in  1  asynchronous, active-low reset.
- sample_valid  in  1  one-cycle strobe; freq_error and PWM are valid in the same cycle.
- freq_error  in  32 signed  measured error from the controller.
- PWM  in  32 signed  current PWM setting from the controller.
- clear  in  1  synchronous restart of lock FSM, averager and event counter.
- locked  out  1  lock qualified (FSM in LOCKED or SLIP).
- lock_state  out  2  0 SEARCH, 1 CONFIRM, 2 LOCKED, 3 SLIP.
- lost_lock  out  1  one-cycle pulse on the SLIP→SEARCH transition.
- avg_error  out  32 signed  last completed block average.
- avg_valid  out  1  one-cycle pulse when avg_error updates.
- pwm_rail  out  1  last sampled PWM was railed.
- unlock_events  out  16  count of lost_lock pulses, saturates at 0xFFFF.

## Operation
- abs_err = |freq_error|. Compute abs of -2^31 as 2^31-1. Use unsigned 32-bit comparisons.
- Good = abs_err ≤ LOCK_TOL. Bad = abs_err > UNLOCK_TOL.
- The FSM advances only on sample_valid. It uses a run counter of 16 bits.
  - SEARCH: good → CONFIRM, run=1. Otherwise stay.
  - CONFIRM: good → run+1. When run+1 = LOCK_COUNT → LOCKED. Not good → SEARCH, run=0.
  - LOCKED: bad → SLIP, run=1. Otherwise stay.
  - SLIP: bad → run+1. When run+1 = UNLOCK_COUNT → SEARCH, pulse lost_lock, increment unlock_events. Not bad → LOCKED, run=0.
- LOCK_COUNT=1 means one good sample in SEARCH goes straight to LOCKED. UNLOCK_COUNT=1 means the same for SLIP→SEARCH.
- The controller's power-up freq_error (99999) is bad, so no special case is needed.
- Averager:
  - Sign-extend freq_error into an accumulator of 32+AVG_LOG2 bits. Keep a sample counter of AVG_LOG2 bits.
  - On the 2^AVG_LOG2-th sample, avg_error = (acc + sample) >>> AVG_LOG2 (arithmetic shift, truncation toward −∞). Then pulse avg_valid and reset acc and the counter to 0.
- pwm_rail = (PWM ≤ RAIL_MARGIN) or (PWM ≥ PWM_MAX − RAIL_MARGIN). It updates only on sample_valid.

## Timing
- Reset values:
  - lock_state 0, locked 0, lost_lock 0, avg_valid 0, pwm_rail 0.
  - avg_error 0, unlock_events 0.
  - run, acc and sample counter 0.
- All outputs are registered. Latency is 1 cycle: outputs reflect sample N in the cycle after its sample_valid.
- lost_lock and avg_valid are high for exactly one cycle. Both may pulse in the same cycle.
- clear:
  - clear wins over a coincident sample_valid; that sample is discarded entirely.
  - Next cycle: SEARCH, run/acc/counter/unlock_events all 0, lost_lock and avg_valid 0.
  - avg_error and pwm_rail hold their values.
- Back-to-back sample_valid (every cycle) must be supported.
- Asynchronous reset mid-block discards the partial average.

## Structure
- A shared package holds:
  - the lock_state encoding constants (SEARCH/CONFIRM/LOCKED/SLIP);
  - a 32-bit saturating abs function, reused by any later error-reporting block.
- One sub-module is natural: vcxo_err_averager (accumulator, sample counter, avg_error/avg_valid). The lock FSM, rail compare and event counter stay in the top.

## Test plan
- Reset, then feed 99999 three times, then freq_error=5 ×8 → lock_state 0,0,0, then 1 after the first good sample. locked=1 one cycle after the 8th good sample.
- Locked; feed errors 50, 50, 5, 50, 50, 50 → SLIP, SLIP, LOCKED, SLIP, SLIP, then SEARCH with one lost_lock pulse; unlock_events=1.
- AVG_LOG2=2; feed -3, -2, -2, -2 → avg_valid pulses once after the 4th sample with avg_error=-3 (−9 >>> 2). Feed -2^31 ×4 → avg_error=-2^31, no overflow. Feed freq_error=-2^31 while locked → counted as bad.
- PWM 500, 20000, 39500 with sample_valid → pwm_rail 1, 0, 1. PWM changes without sample_valid → pwm_rail unchanged.
- Mid-CONFIRM (run=5), assert clear with a coincident good sample_valid → next cycle lock_state=0, run=0, no avg_valid. The next good sample enters CONFIRM with run=1.
- Force 65536 lock losses (or preload the counter) → unlock_events holds at 0xFFFF.

Source files
------------

// File: rtl/vcxo_lock_monitor_pkg.sv
// Shared types and helpers for the VCXO lock monitor and later error-reporting blocks.
package vcxo_lock_monitor_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned RUN_W  = 16;
  localparam int unsigned EVT_W  = 16;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_SLIP    = 2'd3
  } lock_state_e;

  // |x| with the most negative value clamped to the largest positive one.
  function automatic logic [31:0] sat_abs32(input logic signed [31:0] x);
    logic [31:0] r;
    if (x == 32'sh8000_0000)  r = 32'h7FFF_FFFF;
    else if (x[31])           r = 32'(-x);
    else                      r = 32'(x);
    return r;
  endfunction

endpackage

// File: rtl/vcxo_lock_monitor_if.sv
// Sample bus from the VCXO controller: strobe plus error and PWM in the same cycle.
interface vcxo_lock_monitor_if;
  import vcxo_lock_monitor_pkg::*;

  logic                     sample_valid;
  logic signed [DATA_W-1:0] freq_error;
  logic signed [DATA_W-1:0] PWM;

  modport master (output sample_valid, freq_error, PWM);
  modport slave  (input  sample_valid, freq_error, PWM);
endinterface

// File: rtl/vcxo_err_averager.sv
// Block averager: sums 2^AVG_LOG2 samples and publishes the floor-shifted mean.
module vcxo_err_averager
  import vcxo_lock_monitor_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     sample_valid_i,
  input  logic signed [DATA_W-1:0] sample_i,
  output logic signed [DATA_W-1:0] avg_error_o,
  output logic                     avg_valid_o
);

  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
  localparam int unsigned CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** AVG_LOG2) - 1);

  logic signed [ACC_W-1:0]  acc_q, acc_d, sum_c;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_W-1:0] avg_q, avg_d;
  logic                     avg_valid_q, avg_valid_d;

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    sum_c       = acc_q + ACC_W'(sample_i);
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (sample_valid_i) begin
      if (cnt_q == CNT_LAST) begin
        avg_d       = DATA_W'(sum_c >>> AVG_LOG2);
        avg_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = sum_c;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  assign avg_error_o = avg_q;
  assign avg_valid_o = avg_valid_q;

endmodule

// File: rtl/vcxo_lock_monitor.sv
// Lock qualification with hysteresis, PWM rail flag and unlock event counter
// for the VCXO discipline loop; block averaging is delegated to vcxo_err_averager.
module vcxo_lock_monitor
  import vcxo_lock_monitor_pkg::*;
#(
  parameter int unsigned LOCK_TOL     = 10,
  parameter int unsigned UNLOCK_TOL   = 40,
  parameter int unsigned LOCK_COUNT   = 8,
  parameter int unsigned UNLOCK_COUNT = 3,
  parameter int unsigned AVG_LOG2     = 4,
  parameter int unsigned PWM_MAX      = 40000,
  parameter int unsigned RAIL_MARGIN  = 1000
) (
  input  logic                     tcxo_clk_in,
  input  logic                     reset_n,
  vcxo_lock_monitor_if.slave       smp,
  input  logic                     clear,
  output logic                     locked,
  output logic [1:0]               lock_state,
  output logic                     lost_lock,
  output logic signed [DATA_W-1:0] avg_error,
  output logic                     avg_valid,
  output logic                     pwm_rail,
  output logic [EVT_W-1:0]         unlock_events
);

  localparam logic signed [DATA_W-1:0] RAIL_LO = DATA_W'(RAIL_MARGIN);
  localparam logic signed [DATA_W-1:0] RAIL_HI = DATA_W'(PWM_MAX - RAIL_MARGIN);

  lock_state_e      state_q;
  logic [RUN_W-1:0] run_q;
  logic             lost_lock_q;
  logic             pwm_rail_q;
  logic [EVT_W-1:0] evt_q;

  logic [DATA_W-1:0] abs_err_c;
  logic              good_c, bad_c, rail_c;

  assign abs_err_c = sat_abs32(smp.freq_error);
  assign good_c    = abs_err_c <= DATA_W'(LOCK_TOL);
  assign bad_c     = abs_err_c >  DATA_W'(UNLOCK_TOL);
  assign rail_c    = (smp.PWM <= RAIL_LO) || (smp.PWM >= RAIL_HI);

  // Lock FSM; a single-sample threshold skips the intermediate state entirely.
  always_ff @(posedge tcxo_clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_SEARCH;
      run_q       <= '0;
      lost_lock_q <= 1'b0;
      pwm_rail_q  <= 1'b0;
      evt_q       <= '0;
    end else begin
      lost_lock_q <= 1'b0;
      if (clear) begin
        state_q <= ST_SEARCH;
        run_q   <= '0;
        evt_q   <= '0;
      end else if (smp.sample_valid) begin
        pwm_rail_q <= rail_c;
        unique case (state_q)
          ST_SEARCH: begin
            if (good_c) begin
              if (LOCK_COUNT <= 1) begin
                state_q <= ST_LOCKED;
                run_q   <= '0;
              end else begin
                state_q <= ST_CONFIRM;
                run_q   <= RUN_W'(1);
              end
            end
          end
          ST_CONFIRM: begin
            if (!good_c) begin
              state_q <= ST_SEARCH;
              run_q   <= '0;
            end else if (run_q + RUN_W'(1) == RUN_W'(LOCK_COUNT)) begin
              state_q <= ST_LOCKED;
              run_q   <= '0;
            end else begin
              run_q <= run_q + RUN_W'(1);
            end
          end
          ST_LOCKED: begin
            if (bad_c) begin
              if (UNLOCK_COUNT <= 1) begin
                state_q     <= ST_SEARCH;
                run_q       <= '0;
                lost_lock_q <= 1'b1;
                if (evt_q != '1) evt_q <= evt_q + EVT_W'(1);
              end else begin
                state_q <= ST_SLIP;
                run_q   <= RUN_W'(1);
              end
            end
          end
          ST_SLIP: begin
            if (!bad_c) begin
              state_q <= ST_LOCKED;
              run_q   <= '0;
            end else if (run_q + RUN_W'(1) == RUN_W'(UNLOCK_COUNT)) begin
              state_q     <= ST_SEARCH;
              run_q       <= '0;
              lost_lock_q <= 1'b1;
              if (evt_q != '1) evt_q <= evt_q + EVT_W'(1);
            end else begin
              run_q <= run_q + RUN_W'(1);
            end
          end
        endcase
      end
    end
  end

  vcxo_err_averager #(
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk           (tcxo_clk_in),
    .rst_n         (reset_n),
    .clear_i       (clear),
    .sample_valid_i(smp.sample_valid),
    .sample_i      (smp.freq_error),
    .avg_error_o   (avg_error),
    .avg_valid_o   (avg_valid)
  );

  assign lock_state    = state_q;
  assign locked        = state_q[1];
  assign lost_lock     = lost_lock_q;
  assign pwm_rail      = pwm_rail_q;
  assign unlock_events = evt_q;

endmodule

// File: tb/tb_vcxo_lock_monitor.sv
// Directed bench for vcxo_lock_monitor (AVG_LOG2=2, other parameters default).
module tb_vcxo_lock_monitor;
  import vcxo_lock_monitor_pkg::*;

  logic               clk   = 1'b0;
  logic               rst_n = 1'b0;
  logic               clear = 1'b0;
  logic               locked, lost_lock, avg_valid, pwm_rail;
  logic [1:0]         lock_state;
  logic signed [31:0] avg_error;
  logic [15:0]        unlock_events;
  int                 n_cmp = 0;
  int                 n_bad = 0;

  vcxo_lock_monitor_if bus ();

  vcxo_lock_monitor #(.AVG_LOG2(2)) dut (
    .tcxo_clk_in  (clk),
    .reset_n      (rst_n),
    .smp          (bus),
    .clear        (clear),
    .locked       (locked),
    .lock_state   (lock_state),
    .lost_lock    (lost_lock),
    .avg_error    (avg_error),
    .avg_valid    (avg_valid),
    .pwm_rail     (pwm_rail),
    .unlock_events(unlock_events)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [31:0] fe, input logic signed [31:0] pwm);
    bus.sample_valid = 1'b1;
    bus.freq_error   = fe;
    bus.PWM          = pwm;
    step();
    bus.sample_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (lock_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", lock_state); end
    n_cmp++; if ({locked, lost_lock, avg_valid, pwm_rail} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {locked, lost_lock, avg_valid, pwm_rail}); end
    n_cmp++; if (avg_error !== 32'sd0) begin n_bad++; $display("FAIL reset_avg: got %0d want 0", avg_error); end
    n_cmp++; if (unlock_events !== 16'd0) begin n_bad++; $display("FAIL reset_evt: got %0d want 0", unlock_events); end
  endtask

  task automatic test_acquire();
    logic [1:0] exp_st;
    for (int i = 0; i < 3; i++) begin
      send(32'sd99999, 32'sd20000);
      n_cmp++; if (lock_state !== 2'd0) begin n_bad++; $display("FAIL acq_bad[%0d]: got %0d want 0", i, lock_state); end
    end
    for (int i = 0; i < 8; i++) begin
      send(32'sd5, 32'sd20000);
      exp_st = (i == 7) ? 2'd2 : 2'd1;
      n_cmp++; if (lock_state !== exp_st) begin n_bad++; $display("FAIL acq_state[%0d]: got %0d want %0d", i, lock_state, exp_st); end
      n_cmp++; if (locked !== (i == 7)) begin n_bad++; $display("FAIL acq_locked[%0d]: got %0d want %0d", i, locked, (i == 7)); end
    end
  endtask

  task automatic test_slip();
    int errs[6]   = '{50, 50, 5, 50, 50, 50};
    int exp_st[6] = '{3, 3, 2, 3, 3, 0};
    int exp_ll[6] = '{0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      send(32'(errs[i]), 32'sd20000);
      n_cmp++; if (lock_state !== 2'(exp_st[i])) begin n_bad++; $display("FAIL slip_state[%0d]: got %0d want %0d", i, lock_state, exp_st[i]); end
      n_cmp++; if (lost_lock !== 1'(exp_ll[i])) begin n_bad++; $display("FAIL slip_lost[%0d]: got %0d want %0d", i, lost_lock, exp_ll[i]); end
    end
    step();
    n_cmp++; if (lost_lock !== 1'b0) begin n_bad++; $display("FAIL slip_pulse_width: got %0d want 0", lost_lock); end
    n_cmp++; if (unlock_events !== 16'd1) begin n_bad++; $display("FAIL slip_evt: got %0d want 1", unlock_events); end
  endtask

  task automatic test_abs_min();
    repeat (8) send(32'sd5, 32'sd20000);
    n_cmp++; if (lock_state !== 2'd2) begin n_bad++; $display("FAIL absmin_relock: got %0d want 2", lock_state); end
    send(32'sh8000_0000, 32'sd20000);
    n_cmp++; if (lock_state !== 2'd3) begin n_bad++; $display("FAIL absmin_bad: got %0d want 3", lock_state); end
    send(32'sd0, 32'sd20000);
    n_cmp++; if (lock_state !== 2'd2) begin n_bad++; $display("FAIL absmin_recover: got %0d want 2", lock_state); end
  endtask

  task automatic test_avg();
    logic signed [31:0] blk [4][4];
    logic signed [31:0] exp_avg [4];
    blk     = '{'{-3, -2, -2, -2},
                '{32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000},
                '{7, 0, 0, 0},
                '{-1, 0, 0, 0}};
    exp_avg = '{-3, 32'sh8000_0000, 1, -1};
    pulse_clear();
    n_cmp++; if (unlock_events !== 16'd0) begin n_bad++; $display("FAIL avg_clear_evt: got %0d want 0", unlock_events); end
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < 4; s++) begin
        send(blk[b][s], 32'sd20000);
        n_cmp++; if (avg_valid !== (s == 3)) begin n_bad++; $display("FAIL avg_valid[%0d][%0d]: got %0d want %0d", b, s, avg_valid, (s == 3)); end
      end
      n_cmp++; if (avg_error !== exp_avg[b]) begin n_bad++; $display("FAIL avg_value[%0d]: got %0d want %0d", b, avg_error, exp_avg[b]); end
    end
    step();
    n_cmp++; if (avg_valid !== 1'b0) begin n_bad++; $display("FAIL avg_pulse_width: got %0d want 0", avg_valid); end
    n_cmp++; if (avg_error !== -32'sd1) begin n_bad++; $display("FAIL avg_hold: got %0d want -1", avg_error); end
  endtask

  task automatic test_rail();
    int pwm[8] = '{500, 20000, 39500, 1000, 1001, 39000, -5, 38999};
    int exp[8] = '{1, 0, 1, 1, 0, 1, 1, 0};
    for (int i = 0; i < 8; i++) begin
      send(32'sd0, 32'(pwm[i]));
      n_cmp++; if (pwm_rail !== 1'(exp[i])) begin n_bad++; $display("FAIL rail[%0d] pwm=%0d: got %0d want %0d", i, pwm[i], pwm_rail, exp[i]); end
    end
    bus.PWM = 32'sd500;
    repeat (2) step();
    n_cmp++; if (pwm_rail !== 1'b0) begin n_bad++; $display("FAIL rail_no_strobe: got %0d want 0", pwm_rail); end
  endtask

  task automatic test_clear();
    pulse_clear();
    n_cmp++; if (lock_state !== 2'd0) begin n_bad++; $display("FAIL clr_start: got %0d want 0", lock_state); end
    repeat (5) send(32'sd5, 32'sd500);
    n_cmp++; if (lock_state !== 2'd1) begin n_bad++; $display("FAIL clr_confirm: got %0d want 1", lock_state); end
    n_cmp++; if (dut.run_q !== 16'd5) begin n_bad++; $display("FAIL clr_run5: got %0d want 5", dut.run_q); end
    n_cmp++; if (avg_error !== 32'sd5) begin n_bad++; $display("FAIL clr_avg_pre: got %0d want 5", avg_error); end
    clear = 1'b1;
    send(32'sd5, 32'sd20000);
    clear = 1'b0;
    n_cmp++; if (lock_state !== 2'd0) begin n_bad++; $display("FAIL clr_state: got %0d want 0", lock_state); end
    n_cmp++; if (dut.run_q !== 16'd0) begin n_bad++; $display("FAIL clr_run: got %0d want 0", dut.run_q); end
    n_cmp++; if ({avg_valid, lost_lock} !== 2'b00) begin n_bad++; $display("FAIL clr_pulses: got %b want 00", {avg_valid, lost_lock}); end
    n_cmp++; if (avg_error !== 32'sd5) begin n_bad++; $display("FAIL clr_avg_hold: got %0d want 5", avg_error); end
    n_cmp++; if (pwm_rail !== 1'b1) begin n_bad++; $display("FAIL clr_rail_hold: got %0d want 1", pwm_rail); end
    send(32'sd5, 32'sd20000);
    n_cmp++; if (lock_state !== 2'd1) begin n_bad++; $display("FAIL clr_reenter: got %0d want 1", lock_state); end
    n_cmp++; if (dut.run_q !== 16'd1) begin n_bad++; $display("FAIL clr_run1: got %0d want 1", dut.run_q); end
    n_cmp++; if (pwm_rail !== 1'b0) begin n_bad++; $display("FAIL clr_rail_new: got %0d want 0", pwm_rail); end
    for (int i = 0; i < 3; i++) begin
      send(32'sd8, 32'sd20000);
      n_cmp++; if (avg_valid !== (i == 2)) begin n_bad++; $display("FAIL clr_avg_valid[%0d]: got %0d want %0d", i, avg_valid, (i == 2)); end
    end
    n_cmp++; if (avg_error !== 32'sd7) begin n_bad++; $display("FAIL clr_avg_value: got %0d want 7", avg_error); end
  endtask

  task automatic test_saturate();
    repeat (4) send(32'sd5, 32'sd20000);
    n_cmp++; if (lock_state !== 2'd2) begin n_bad++; $display("FAIL sat_locked: got %0d want 2", lock_state); end
    force dut.evt_q = 16'hFFFE;
    step();
    release dut.evt_q;
    step();
    n_cmp++; if (unlock_events !== 16'hFFFE) begin n_bad++; $display("FAIL sat_preload: got %h want fffe", unlock_events); end
    repeat (3) send(32'sd99999, 32'sd20000);
    n_cmp++; if (lost_lock !== 1'b1) begin n_bad++; $display("FAIL sat_lost1: got %0d want 1", lost_lock); end
    n_cmp++; if (unlock_events !== 16'hFFFF) begin n_bad++; $display("FAIL sat_reach: got %h want ffff", unlock_events); end
    repeat (8) send(32'sd5, 32'sd20000);
    repeat (3) send(32'sd99999, 32'sd20000);
    n_cmp++; if (lost_lock !== 1'b1) begin n_bad++; $display("FAIL sat_lost2: got %0d want 1", lost_lock); end
    n_cmp++; if (unlock_events !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold: got %h want ffff", unlock_events); end
  endtask

  task automatic test_async_reset();
    pulse_clear();
    send(-32'sd8, 32'sd500);
    send(-32'sd8, 32'sd500);
    rst_n = 1'b0;
    #2;
    n_cmp++; if (avg_error !== 32'sd0) begin n_bad++; $display("FAIL arst_avg: got %0d want 0", avg_error); end
    n_cmp++; if (pwm_rail !== 1'b0) begin n_bad++; $display("FAIL arst_rail: got %0d want 0", pwm_rail); end
    n_cmp++; if (unlock_events !== 16'd0) begin n_bad++; $display("FAIL arst_evt: got %0d want 0", unlock_events); end
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      send(32'sd4, 32'sd20000);
      n_cmp++; if (avg_valid !== (i == 3)) begin n_bad++; $display("FAIL arst_avg_valid[%0d]: got %0d want %0d", i, avg_valid, (i == 3)); end
    end
    n_cmp++; if (avg_error !== 32'sd4) begin n_bad++; $display("FAIL arst_avg_value: got %0d want 4", avg_error); end
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.freq_error   = '0;
    bus.PWM          = '0;
    test_reset();
    test_acquire();
    test_slip();
    test_abs_min();
    test_avg();
    test_rail();
    test_clear();
    test_saturate();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
